// File: rtl/alu_uart_if.sv
// rtl/alu_uart_if.sv - UART byte-stream framing front end for the ALU (optional INTERBYTE_TIMEOUT_EN)
module alu_uart_if #(
    parameter int NB_REG         = 16,
    parameter int NB_OP          = 6,
    parameter int NB_BYTE        = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic [NB_REG-1:0]  o_alu_a,
    output logic [NB_REG-1:0]  o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_REG-1:0]  i_alu_result,
    output logic               o_busy,
    output logic               o_rx_drop,
    output logic               o_err
);
    localparam int NB_BYTES = NB_REG / NB_BYTE;
    localparam int CW       = $clog2(NB_BYTES + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(NB_BYTES - 1);

    typedef enum logic [2:0] {RX_A, RX_B, RX_OP, EXEC, TX_LOAD, TX_WAIT} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NB_REG-1:0]   asm_q, asm_d, asm_next;
    logic [NB_REG-1:0]   tx_sr_q, tx_sr_d;
    logic [NB_REG-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [NB_OP-1:0]    alu_op_q, alu_op_d;
    logic [NB_BYTE-1:0]  tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                busy_q, busy_d;
    logic                rx_drop_q, rx_drop_d;
    logic                rx_state;

`ifdef INTERBYTE_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;
`endif

    assign rx_state = (state_q == RX_A) || (state_q == RX_B) || (state_q == RX_OP);
    // Bytes arrive LSB first, so each new byte enters at the top and the word slides down.
    assign asm_next = (asm_q >> NB_BYTE) | (NB_REG'(i_rx_data) << (NB_REG - NB_BYTE));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        asm_d      = asm_q;
        tx_sr_d    = tx_sr_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        rx_drop_d  = i_rx_valid && !rx_state;
`ifdef INTERBYTE_TIMEOUT_EN
        timer_d    = '0;
        err_d      = 1'b0;
`endif
        case (state_q)
            RX_A, RX_B: begin
                if (i_rx_valid) begin
                    if (cnt_q == LAST_BYTE) begin
                        if (state_q == RX_A) begin
                            alu_a_d = asm_next;
                            state_d = RX_B;
                        end else begin
                            alu_b_d = asm_next;
                            state_d = RX_OP;
                        end
                        asm_d = '0;
                        cnt_d = '0;
                    end else begin
                        asm_d = asm_next;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            RX_OP: begin
                if (i_rx_valid) begin
                    alu_op_d = i_rx_data[NB_OP-1:0];
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                tx_sr_d = i_alu_result;
                cnt_d   = '0;
                state_d = TX_LOAD;
            end
            TX_LOAD: begin
                tx_data_d  = tx_sr_q[NB_BYTE-1:0];
                tx_start_d = 1'b1;
                state_d    = TX_WAIT;
            end
            TX_WAIT: begin
                if (i_tx_done) begin
                    tx_sr_d = tx_sr_q >> NB_BYTE;
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = RX_A;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = TX_LOAD;
                    end
                end
            end
            default: state_d = RX_A;
        endcase
`ifdef INTERBYTE_TIMEOUT_EN
        // The timer only arms once a frame is partially received; an idle RX_A never times out.
        if (rx_state && !i_rx_valid && (state_q != RX_A || cnt_q != '0)) begin
            if (timer_q == TIMER_LAST) begin
                err_d   = 1'b1;
                asm_d   = '0;
                cnt_d   = '0;
                state_d = RX_A;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
`endif
        busy_d = (state_d == EXEC) || (state_d == TX_LOAD) || (state_d == TX_WAIT);
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= RX_A;
            cnt_q      <= '0;
            asm_q      <= '0;
            tx_sr_q    <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            rx_drop_q  <= 1'b0;
`ifdef INTERBYTE_TIMEOUT_EN
            timer_q    <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            asm_q      <= asm_d;
            tx_sr_q    <= tx_sr_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            rx_drop_q  <= rx_drop_d;
`ifdef INTERBYTE_TIMEOUT_EN
            timer_q    <= timer_d;
            err_q      <= err_d;
`endif
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_busy     = busy_q;
    assign o_rx_drop  = rx_drop_q;
`ifdef INTERBYTE_TIMEOUT_EN
    assign o_err      = err_q;
`else
    assign o_err      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_uart_if.sv
// tb/tb_alu_uart_if.sv - directed self-checking bench for alu_uart_if
module tb_alu_uart_if;
    logic        clk = 1'b0;
    logic        i_rst_n;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_done;
    logic [15:0] o_alu_a, o_alu_b;
    logic [5:0]  o_alu_op;
    logic [15:0] i_alu_result;
    logic        o_busy, o_rx_drop, o_err;

    int n_cmp = 0;
    int n_bad = 0;
    int drop_cnt = 0;
    int err_cnt = 0;
    int tx_cd = 0;
    logic [7:0] tx_q[$];

    always #5 clk = ~clk;

    alu_uart_if #(.NB_REG(16), .NB_OP(6), .NB_BYTE(8), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .i_rst_n(i_rst_n),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
        .i_alu_result(i_alu_result),
        .o_busy(o_busy), .o_rx_drop(o_rx_drop), .o_err(o_err)
    );

    always_comb begin
        case (o_alu_op)
            6'h20:   i_alu_result = o_alu_a + o_alu_b;
            6'h22:   i_alu_result = o_alu_a - o_alu_b;
            6'h24:   i_alu_result = o_alu_a & o_alu_b;
            6'h25:   i_alu_result = o_alu_a | o_alu_b;
            default: i_alu_result = 16'h0000;
        endcase
    end

    // UART TX stand-in: done strobe 10 cycles after each start; also records sent bytes and pulses.
    initial begin
        i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            i_tx_done = 1'b0;
            if (!i_rst_n) begin
                tx_cd = 0;
            end else if (o_tx_start) begin
                tx_q.push_back(o_tx_data);
                tx_cd = 10;
            end else if (tx_cd > 0) begin
                tx_cd--;
                if (tx_cd == 0) i_tx_done = 1'b1;
            end
            if (o_rx_drop) drop_cnt++;
            if (o_err) err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op);
        send_byte(a[7:0]);
        send_byte(a[15:8]);
        send_byte(b[7:0]);
        send_byte(b[15:8]);
        send_byte(op);
    endtask

    task automatic expect_resp(input string tag, input logic [7:0] b0, input logic [7:0] b1);
        int k;
        k = 0;
        while ((tx_q.size() < 2 || o_busy) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_nbytes"}, tx_q.size(), 2);
        if (tx_q.size() >= 2) begin
            check({tag, "_byte0"}, tx_q[0], b0);
            check({tag, "_byte1"}, tx_q[1], b1);
        end
        tx_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_alu_a"}, o_alu_a, 0);
        check({tag, "_alu_b"}, o_alu_b, 0);
        check({tag, "_alu_op"}, o_alu_op, 0);
        check({tag, "_tx_data"}, o_tx_data, 0);
        check({tag, "_tx_start"}, o_tx_start, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_rx_drop"}, o_rx_drop, 0);
        check({tag, "_err"}, o_err, 0);
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        i_rst_n = 1'b1;

        // ADD frame with latency check and a byte dropped mid-response
        send_frame(16'h1234, 16'h0001, 8'h20);
        check("t1_alu_a", o_alu_a, 16'h1234);
        check("t1_alu_b", o_alu_b, 16'h0001);
        check("t1_alu_op", o_alu_op, 6'h20);
        check("t1_busy", o_busy, 1);
        @(negedge clk);
        check("t1_start_early", o_tx_start, 0);
        @(negedge clk);
        check("t1_start_lat3", o_tx_start, 1);
        check("t1_tx_data0", o_tx_data, 8'h35);
        repeat (3) @(negedge clk);
        send_byte(8'hAA);
        expect_resp("t1", 8'h35, 8'h12);
        check("t3_drop_cnt", drop_cnt, 1);
        check("t3_alu_a_kept", o_alu_a, 16'h1234);
        check("t1_tx_data_hold", o_tx_data, 8'h12);

        // Back-to-back frames, next frame starts the cycle busy drops
        send_frame(16'h0005, 16'h0007, 8'h22);
        expect_resp("t2_sub", 8'hFE, 8'hFF);
        send_frame(16'h000F, 16'h003C, 8'h24);
        expect_resp("t2_and", 8'h0C, 8'h00);
        check("t2_alu_op", o_alu_op, 6'h24);

        // Reset after 3 of 5 bytes
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'h01);
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("t4_rst");
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        send_frame(16'h000A, 16'h0005, 8'h20);
        expect_resp("t4_add", 8'h0F, 8'h00);
        check("t4_alu_a", o_alu_a, 16'h000A);

        // Reset during TX: no further start strobes
        send_frame(16'h0100, 16'h0200, 8'h25);
        for (int k = 0; k < 50 && tx_q.size() < 1; k++) @(negedge clk);
        check("t4b_first_byte", tx_q.size(), 1);
        i_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("t4b_no_more_tx", tx_q.size(), 1);
        check("t4b_busy", o_busy, 0);
        tx_q.delete();

        // Opcode byte FF keeps only the low 6 bits
        send_frame(16'h1111, 16'h2222, 8'hFF);
        check("t6_alu_op", o_alu_op, 6'h3F);
        expect_resp("t6", 8'h00, 8'h00);

`ifdef INTERBYTE_TIMEOUT_EN
        send_byte(8'h77);
        send_byte(8'h66);
        for (int k = 0; k < 150 && err_cnt == 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("t5_err_cnt", err_cnt, 1);
        check("t5_alu_op_kept", o_alu_op, 6'h3F);
        send_frame(16'h0001, 16'h0002, 8'h20);
        check("t5_alu_a", o_alu_a, 16'h0001);
        expect_resp("t5", 8'h03, 8'h00);
`else
        check("no_err_pulses", err_cnt, 0);
`endif
        check("drop_total", drop_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
